// File: rtl/osc_i2s_tx.sv
// Philips-format I2S transmitter: latches a left/right oscillator sample pair once per
// 64-slot frame and shifts it out MSB first on SD, with WS leading each channel by one SCLK.
module osc_i2s_tx #(
    parameter int AUDIO_WIDTH_P    = 24,
    parameter int SCLK_DIV_WIDTH_P = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [AUDIO_WIDTH_P-1:0]    osc_left,
    input  logic [AUDIO_WIDTH_P-1:0]    osc_right,
    input  logic                        cr_enable,
    input  logic [SCLK_DIV_WIDTH_P-1:0] cr_sclk_half_period,
    output logic                        i2s_sclk,
    output logic                        i2s_ws,
    output logic                        i2s_sd,
    output logic                        sample_taken,
    output logic                        dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                      state_q, state_d;
    logic [SCLK_DIV_WIDTH_P-1:0] half_q, half_d;
    logic [SCLK_DIV_WIDTH_P-1:0] div_q, div_d;
    logic [5:0]                  slot_q, slot_d;
    logic [31:0]                 left_q, left_d;
    logic [31:0]                 right_q, right_d;
    logic                        sclk_q, sclk_d;
    logic                        ws_q, ws_d;
    logic                        sd_q, sd_d;
    logic                        taken_q, taken_d;

    logic [SCLK_DIV_WIDTH_P-1:0] half_eff;
    logic [5:0]                  slot_next;

    // MSB-align a sample in the 32-bit slot word, zero-padding the unused LSBs.
    function automatic logic [31:0] slot_word(input logic [AUDIO_WIDTH_P-1:0] s);
        logic [31:0] w;
        w = '0;
        w[31 -: AUDIO_WIDTH_P] = s;
        return w;
    endfunction

    assign half_eff  = (cr_sclk_half_period == '0) ? SCLK_DIV_WIDTH_P'(1) : cr_sclk_half_period;
    assign slot_next = slot_q + 6'd1;

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        div_d   = div_q;
        slot_d  = slot_q;
        left_d  = left_q;
        right_d = right_q;
        sclk_d  = sclk_q;
        ws_d    = ws_q;
        sd_d    = sd_q;
        taken_d = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d = 1'b0;
                ws_d   = 1'b0;
                sd_d   = 1'b0;
                slot_d = 6'd63;
                div_d  = '0;
                if (cr_enable) begin
                    state_d = RUN;
                    half_d  = half_eff;
                end
            end
            RUN: begin
                if (div_q == half_q - SCLK_DIV_WIDTH_P'(1)) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        // Falling toggle: enter the next slot; both halves index bit 31-(s mod 32).
                        slot_d = slot_next;
                        ws_d   = (slot_next >= 6'd31) && (slot_next <= 6'd62);
                        sd_d   = slot_next[5] ? right_q[~slot_next[4:0]] : left_q[~slot_next[4:0]];
                        if (slot_next == 6'd0) begin
                            if (!cr_enable) begin
                                state_d = IDLE;
                                sclk_d  = 1'b0;
                                ws_d    = 1'b0;
                                sd_d    = 1'b0;
                                slot_d  = 6'd63;
                            end else begin
                                left_d  = slot_word(osc_left);
                                right_d = slot_word(osc_right);
                                sd_d    = osc_left[AUDIO_WIDTH_P-1];
                                taken_d = 1'b1;
                                half_d  = half_eff;
                            end
                        end
                    end
                end else begin
                    div_d = div_q + SCLK_DIV_WIDTH_P'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            half_q  <= SCLK_DIV_WIDTH_P'(1);
            div_q   <= '0;
            slot_q  <= 6'd63;
            left_q  <= '0;
            right_q <= '0;
            sclk_q  <= 1'b0;
            ws_q    <= 1'b0;
            sd_q    <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            div_q   <= div_d;
            slot_q  <= slot_d;
            left_q  <= left_d;
            right_q <= right_d;
            sclk_q  <= sclk_d;
            ws_q    <= ws_d;
            sd_q    <= sd_d;
            taken_q <= taken_d;
        end
    end

    assign i2s_sclk     = sclk_q;
    assign i2s_ws       = ws_q;
    assign i2s_sd       = sd_q;
    assign sample_taken = taken_q;
    assign dbg_state    = (state_q == RUN);

endmodule

// File: tb/tb_osc_i2s_tx.sv
// Bench for osc_i2s_tx: directed scenario sequence with randomized samples, checked every
// clk against a frame-level timing model (cycle offset within frame -> slot, SCLK, WS, SD bit).
module tb_osc_i2s_tx;
  localparam int AW = 24;
  localparam int SW = 8;
  localparam int BUDGET = 20000;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] osc_left;
  logic [AW-1:0] osc_right;
  logic          cr_enable;
  logic [SW-1:0] cr_sclk_half_period;
  logic          i2s_sclk;
  logic          i2s_ws;
  logic          i2s_sd;
  logic          sample_taken;
  logic          dbg_state;

  osc_i2s_tx #(.AUDIO_WIDTH_P(AW), .SCLK_DIV_WIDTH_P(SW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .osc_left            (osc_left),
    .osc_right           (osc_right),
    .cr_enable           (cr_enable),
    .cr_sclk_half_period (cr_sclk_half_period),
    .i2s_sclk            (i2s_sclk),
    .i2s_ws              (i2s_ws),
    .i2s_sd              (i2s_sd),
    .sample_taken        (sample_taken),
    .dbg_state           (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: running flag, lead-in phase, cycle offset, half period, frame word
  bit          m_run = 1'b0;
  bit          m_pre = 1'b0;
  int          m_j = 0;
  int          m_h = 1;
  logic [63:0] m_frame = '0;
  int          n_frames = 0;
  bit          rnd_osc = 1'b0;

  function automatic int eff_half(input logic [SW-1:0] h);
    return (h == '0) ? 1 : int'(h);
  endfunction

  function automatic logic [31:0] pad(input logic [AW-1:0] v);
    return 32'(v) << (32 - AW);
  endfunction

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, got, exp);
    end
  endtask

  // driver: one clk edge, model update with the inputs seen at that edge, then output check
  task automatic step();
    int  s;
    logic e_sclk, e_ws, e_sd, e_tk;
    @(posedge clk);
    if (!rst_n) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (cr_enable) begin
        m_run = 1'b1;
        m_pre = 1'b1;
        m_j   = 0;
        m_h   = eff_half(cr_sclk_half_period);
      end
    end else begin
      m_j++;
      if ((m_pre && m_j == 2 * m_h) || (!m_pre && m_j == 128 * m_h)) begin
        if (cr_enable) begin
          m_pre   = 1'b0;
          m_j     = 0;
          m_h     = eff_half(cr_sclk_half_period);
          m_frame = {pad(osc_left), pad(osc_right)};
          n_frames++;
        end else begin
          m_run = 1'b0;
        end
      end
    end
    #1;
    e_sclk = 1'b0; e_ws = 1'b0; e_sd = 1'b0; e_tk = 1'b0;
    if (m_run && m_pre) begin
      e_sclk = (m_j >= m_h);
    end else if (m_run) begin
      s      = m_j / (2 * m_h);
      e_sclk = ((m_j / m_h) % 2) == 1;
      e_ws   = (s >= 31) && (s <= 62);
      e_sd   = m_frame[63 - s];
      e_tk   = (m_j == 0);
    end
    check("sclk", i2s_sclk, e_sclk);
    check("ws", i2s_ws, e_ws);
    check("sd", i2s_sd, e_sd);
    check("sample_taken", sample_taken, e_tk);
    check("state", dbg_state, m_run);
    if (rnd_osc) begin
      osc_left  = AW'($urandom);
      osc_right = AW'($urandom);
    end
  endtask

  task automatic run_to_slot(input int slot);
    int b = 0;
    while (!(m_run && !m_pre && (m_j / (2 * m_h)) == slot) && b < BUDGET) begin
      step();
      b++;
    end
    n_cmp++;
    assert (b < BUDGET) else begin
      n_err++;
      $error("FAIL wait_slot%0d observed=%0d cycles expected<%0d", slot, b, BUDGET);
    end
  endtask

  task automatic run_frames(input int n);
    int b = 0;
    int target = n_frames + n;
    while (n_frames < target && b < BUDGET) begin
      step();
      b++;
    end
    n_cmp++;
    assert (b < BUDGET) else begin
      n_err++;
      $error("FAIL wait_frames observed=%0d cycles expected<%0d", b, BUDGET);
    end
  endtask

  task automatic run_to_idle();
    int b = 0;
    while (m_run && b < BUDGET) begin
      step();
      b++;
    end
    n_cmp++;
    assert (b < BUDGET) else begin
      n_err++;
      $error("FAIL wait_idle observed=%0d cycles expected<%0d", b, BUDGET);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cr_enable = 1'b0;
    cr_sclk_half_period = SW'(2);
    osc_left = '0;
    osc_right = '0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    // fixed pattern frame at H=2, then randomized samples
    osc_left  = AW'(24'hABCDEF);
    osc_right = AW'(24'h123456);
    cr_enable = 1'b1;
    run_frames(1);
    rnd_osc = 1'b1;
    run_frames(1);

    // half period change mid-frame applies from the next frame
    run_to_slot(20);
    cr_sclk_half_period = SW'(5);
    run_frames(2);

    // drop enable at slot 10: frame completes, then idle
    run_to_slot(10);
    cr_enable = 1'b0;
    run_to_idle();
    repeat (20) step();

    // enable from idle with H=3
    cr_sclk_half_period = SW'(3);
    cr_enable = 1'b1;
    run_frames(3);

    // H=0 behaves as H=1
    cr_sclk_half_period = SW'(0);
    run_frames(3);

    // random half periods
    for (int i = 0; i < 4; i++) begin
      cr_sclk_half_period = SW'($urandom_range(0, 4));
      run_frames(1);
    end

    // asynchronous reset at slot 40
    cr_sclk_half_period = SW'(2);
    run_to_slot(40);
    run_to_slot(40);
    #2 rst_n = 1'b0;
    m_run = 1'b0;
    #1;
    check("async_sclk", i2s_sclk, 1'b0);
    check("async_ws", i2s_ws, 1'b0);
    check("async_sd", i2s_sd, 1'b0);
    check("async_taken", sample_taken, 1'b0);
    check("async_state", dbg_state, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    cr_sclk_half_period = SW'(3);
    run_frames(2);

    cr_enable = 1'b0;
    run_to_idle();
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/osc_i2s_tx.md
# osc_i2s_tx

Downstream consumer of the oscillator stage. Takes parallel left/right oscillator samples and serialises them as a Philips-format I2S stream (SCLK, WS, SD) for an external DAC. The frame has 64 SCLK slots, 32 per channel. Samples are latched once per frame, and the output sample rate is f_clk / (128·H), where H is the programmed SCLK half-period.

## Interface
- AUDIO_WIDTH_P, default 24: sample width in bits. Legal range is 1..32. Samples are MSB-aligned in the 32-bit slot word and zero-padded below.
- SCLK_DIV_WIDTH_P, default 8: width of the SCLK half-period register.
- clk  input  1  system clock. All logic is on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- osc_left  input  AUDIO_WIDTH_P  left-channel sample, two's complement, from the oscillator.
- osc_right  input  AUDIO_WIDTH_P  right-channel sample, two's complement.
- cr_enable  input  1  run request. Level-sensitive.
- cr_sclk_half_period  input  SCLK_DIV_WIDTH_P  H, the number of clk cycles per SCLK half-period. A value of 0 is treated as 1.
- i2s_sclk  output  1  serial bit clock, registered.
- i2s_ws  output  1  word select: 0 = left, 1 = right. Registered.
- i2s_sd  output  1  serial data, MSB first, registered.
- sample_taken  output  1  one-clk pulse when osc_left/osc_right are latched.

## Operation
- States: IDLE and RUN.
- Internal registers:
  - half: latched H
  - div_cnt: counts 0..half-1
  - slot: 6-bit, 0..63
  - left_word and right_word: 32-bit each
- Reset, and IDLE:
  - i2s_sclk = i2s_ws = i2s_sd = sample_taken = 0
  - slot = 63, div_cnt = 0
  - state = IDLE
- IDLE -> RUN when cr_enable = 1. Latch half = max(cr_sclk_half_period, 1) and clear div_cnt.
- Divider in RUN:
  - When div_cnt == half-1: toggle i2s_sclk and set div_cnt = 0.
  - Otherwise: div_cnt += 1.
- Every falling SCLK toggle (i2s_sclk 1 -> 0) advances slot to s' = slot+1 mod 64. In the same clk edge:
  - i2s_ws <= 1 for s' in 31..62; 0 for s' = 63 and for 0..30.
  - Slots 0..31: i2s_sd <= left_word bit (31-s').
  - Slots 32..63: i2s_sd <= right_word bit (63-s').
- Frame boundary, when s' = 0:
  - If cr_enable = 0: go to IDLE and drive all outputs to reset values. No sample is taken.
  - Otherwise:
    - left_word <= {osc_left, zeros}
    - right_word <= {osc_right, zeros}
    - Both are captured in the same clk cycle, so the channel pair stays coherent.
    - i2s_sd <= osc_left MSB directly.
    - sample_taken <= 1 for exactly one cycle.
    - half <= max(cr_sclk_half_period, 1).
- cr_sclk_half_period changes take effect only at the IDLE->RUN transition or at a frame boundary, never mid-frame.
- Deasserting cr_enable mid-frame does not truncate: slots through 63 complete, then the block enters IDLE at the next boundary.
- Receivers sample on the rising SCLK edge. SD and WS change only on falling toggles, so they are stable for a full half-period around each rising edge.

## Timing
- SCLK period is 2·half clk cycles. A frame is 128·half clk cycles.
- From enable:
  - cr_enable sampled high at edge E0 puts the block in RUN.
  - First SCLK rise at E0 + half.
  - First falling toggle at E0 + 2·half. This enters slot 0, pulses sample_taken and drives the left MSB on i2s_sd, all in the same cycle.
- sample_taken repeats every 128·half cycles while enabled.
- Latency from sample capture to MSB on i2s_sd is 0 cycles: both are registered on the same edge. LSB padding ends at slot 31 (left) and slot 63 (right).
- WS leads each channel's MSB by one SCLK:
  - WS falls entering slot 63; left MSB appears at slot 0.
  - WS rises entering slot 31; right MSB appears at slot 32.
- Asynchronous reset at any point immediately forces all outputs to 0 and the state to IDLE. There is no partial-frame recovery.

## Test plan
- H=2, AUDIO_WIDTH_P=24, left=0xABCDEF, right=0x123456 -> SCLK period 4 clk. SD over slots 0..63 equals 0xABCDEF00 then 0x12345600, MSB first. WS is high exactly in slots 31..62.
- Enable from IDLE with H=3 -> SCLK first rises 3 clk after the enable edge. sample_taken pulses once at +6 clk, then every 384 clk.
- Write H=2 -> 5 mid-frame -> remainder of that frame keeps 4-clk SCLK. The next frame, starting at slot 0, uses 10-clk SCLK.
- Drop cr_enable at slot 10 -> slots 11..63 still transmit. At the next boundary all outputs go to 0, with no further sample_taken.
- H=0 -> behaves as H=1: SCLK toggles every clk, and the frame is 128 clk.
- Assert rst_n low at slot 40 -> sclk/ws/sd/sample_taken go to 0 asynchronously. After release with cr_enable=1, the restart timing matches the enable scenario.
